// File: rtl/gf_pkg.sv
// Shared constants and types for the serial GF(2^M) multiplier.
package gf_pkg;

  localparam int GF_M = 4;
  localparam logic [GF_M-1:0] GF_POLY = 4'b0011;
  localparam int GF_CNT_W = $clog2(GF_M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_e;

endpackage

// File: rtl/gf_xtime.sv
// Multiply-by-x in GF(2^M): shift left one place and reduce by x^M + POLY.
module gf_xtime
  import gf_pkg::*;
#(
  parameter int M = GF_M,
  parameter logic [M-1:0] POLY = GF_POLY
) (
  input  logic [M-1:0] din,
  output logic [M-1:0] dout
);

  assign dout = {din[M-2:0], 1'b0} ^ (POLY & {M{din[M-1]}});

endmodule

// File: rtl/gf_serial_mult.sv
// Bit-serial GF(2^M) multiplier, one multiplier bit per cycle, MSB first.
// Optional multiply-accumulate into p when GF_MULT_ACC_EN is defined.
module gf_serial_mult
  import gf_pkg::*;
#(
  parameter int M = GF_M,
  parameter logic [M-1:0] POLY = GF_POLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
`ifdef GF_MULT_ACC_EN
  input  logic         acc_mode,
`endif
  output logic         busy,
  output logic         done,
  output logic [M-1:0] p
);

  localparam int CNT_W = $clog2(M);

  gf_state_e        state_r;
  gf_state_e        state_s;
  logic [M-1:0]     a_r;
  logic [M-1:0]     b_r;
  logic [M-1:0]     acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [M-1:0]     xt_s;
  logic [M-1:0]     acc_next_s;
  logic [M-1:0]     p_new_s;
`ifdef GF_MULT_ACC_EN
  logic             acc_mode_r;
`endif

  gf_xtime #(
    .M    (M),
    .POLY (POLY)
  ) u_xtime (
    .din  (acc_r),
    .dout (xt_s)
  );

  // Horner step: shift-and-reduce the accumulator, then add a if this b bit is set.
  assign acc_next_s = xt_s ^ (a_r & {M{b_r[cnt_r]}});

  // Value written to p on completion (plain product or multiply-accumulate).
  always_comb begin
    p_new_s = acc_next_s;
`ifdef GF_MULT_ACC_EN
    if (acc_mode_r) begin
      p_new_s = p ^ acc_next_s;
    end else begin
      p_new_s = acc_next_s;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      p          <= {M{1'b0}};
      a_r        <= {M{1'b0}};
      b_r        <= {M{1'b0}};
      acc_r      <= {M{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
`ifdef GF_MULT_ACC_EN
      acc_mode_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      done    <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r        <= a;
            b_r        <= b;
            acc_r      <= {M{1'b0}};
            cnt_r      <= CNT_W'(M - 1);
`ifdef GF_MULT_ACC_EN
            acc_mode_r <= acc_mode;
`endif
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          if (cnt_r == {CNT_W{1'b0}}) begin
            p <= p_new_s;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_serial_mult.sv
// Directed and exhaustive checks of gf_serial_mult (M=4, x^4+x+1).
module tb_gf_serial_mult;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] p;
`ifdef GF_MULT_ACC_EN
  logic       acc_mode;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] p;
  } vec_t;

  vec_t       tbl [8];
  logic [3:0] res_tab [16][16];

  gf_serial_mult dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef GF_MULT_ACC_EN
    .acc_mode (acc_mode),
`endif
    .busy     (busy),
    .done     (done),
    .p        (p)
  );

  always #5 clk = ~clk;

  // LSB-first shift-and-add reference, independent of the DUT's MSB-first order.
  function automatic logic [3:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    logic [3:0] s;
    r = 4'h0;
    s = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) r = r ^ s;
      s = {s[2:0], 1'b0} ^ (s[3] ? 4'b0011 : 4'b0000);
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge while the DUT is idle; start is taken at the next posedge.
  task automatic run_mult(input logic [3:0] ta, input logic [3:0] tb, input bit timing,
                          output logic [3:0] res);
    int cyc;
    int busy_n;
    bit seen;
    a = ta;
    b = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busy_n = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    res = p;
    if (timing) begin
      check("done_seen", int'(seen), 1);
      check("latency", cyc, 4);
    end else if (!seen) begin
      check("timeout", 0, 1);
    end
    @(negedge clk);
    if (timing) begin
      if (busy) busy_n++;
      check("busy_cycles", busy_n, 5);
      check("done_one_cycle", int'(done), 0);
    end
  endtask

  initial begin
    logic [3:0] r;
    int dn;

    rst_n = 1'b0;
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
`ifdef GF_MULT_ACC_EN
    acc_mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_p", int'(p), 0);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{4'h2, 4'h8, 4'h3};
    tbl[1] = '{4'hF, 4'hF, 4'hA};
    tbl[2] = '{4'h7, 4'h0, 4'h0};
    tbl[3] = '{4'h1, 4'hB, 4'hB};
    tbl[4] = '{4'h3, 4'h7, 4'h9};
    tbl[5] = '{4'h8, 4'h8, 4'hC};
    tbl[6] = '{4'h4, 4'h4, 4'h3};
    tbl[7] = '{4'hA, 4'h5, 4'h4};
    for (int i = 0; i < 8; i++) begin
      run_mult(tbl[i].a, tbl[i].b, 1'b1, r);
      check($sformatf("vec%0d p", i), int'(r), int'(tbl[i].p));
    end

    // start while busy must be ignored
    a = 4'hF; b = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'h1; b = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'h0; b = 4'h0;
    dn = 0;
    repeat (10) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("busy_prot_pulses", dn, 1);
    check("busy_prot_p", int'(p), 'hA);

    // reset two edges into a run aborts it
    a = 4'hF; b = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_p", int'(p), 0);
    rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_p_held", int'(p), 0);

    // start coincident with reset is ignored
    rst_n = 1'b0; a = 4'h3; b = 4'h7; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", int'(busy), 0);
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("rst_start_no_done", dn, 0);
    check("rst_start_p", int'(p), 0);

`ifdef GF_MULT_ACC_EN
    acc_mode = 1'b0;
    run_mult(4'h2, 4'h8, 1'b1, r);
    check("mac_plain", int'(r), 3);
    acc_mode = 1'b1;
    run_mult(4'h2, 4'h8, 1'b1, r);
    check("mac_accum", int'(r), 0);
    acc_mode = 1'b0;
`endif

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_mult(4'(x), 4'(y), 1'b0, r);
        res_tab[x][y] = r;
        check($sformatf("sweep %0h*%0h", x, y), int'(r), int'(ref_mul(4'(x), 4'(y))));
      end
    end
    for (int x = 0; x < 16; x++) begin
      for (int y = x + 1; y < 16; y++) begin
        check($sformatf("commute %0h*%0h", x, y), int'(res_tab[x][y]), int'(res_tab[y][x]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
